// File: rtl/usbfs_pkg.sv
// Shared USB full-speed definitions: PID encodings, CRC16 constants, FSM state type and helpers.
package usbfs_pkg;

  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  localparam logic [15:0] Crc16Poly = 16'hA001;
  localparam logic [15:0] Crc16Init = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPid,
    StData,
    StCrcLo,
    StCrcHi
  } tx_state_e;

  function automatic logic isDataPid(input logic [3:0] pid);
    return (pid == PidData0) || (pid == PidData1);
  endfunction

  // Reflected CRC16 update, one byte processed LSB-first.
  function automatic logic [15:0] crc16Upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ Crc16Poly;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usbfs_crc16.sv
// Registered CRC16 accumulator; init has priority over enable. Shared by TX and RX paths.
module usbfs_crc16
  import usbfs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) crc_q <= Crc16Init;
    else if (en_i)       crc_q <= crc16Upd(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usbfs_tx_pkt.sv
// TX packet assembly: buffers endpoint payload and streams PID, payload and CRC16 bytes
// to the bit-level serializer.
module usbfs_tx_pkt
  import usbfs_pkg::*;
#(
  parameter int unsigned MAX_PKT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_txReqReady,
  input  logic                       i_txReq,
  input  logic [3:0]                 i_txPid,
  output logic                       o_txDone,
  output logic                       o_etTxAccepted,
  input  logic                       i_etWrEn,
  input  logic [$clog2(MAX_PKT)-1:0] i_etWrIdx,
  input  logic [7:0]                 i_etWrByte,
  output logic                       o_txValid,
  input  logic                       i_txReady,
  output logic [7:0]                 o_txData,
  output logic                       o_txLast
);

  localparam int unsigned IdxW  = $clog2(MAX_PKT);
  localparam int unsigned CntW  = $clog2(MAX_PKT + 1);
  localparam int unsigned FillW = $clog2(MAX_PKT + 3);

  tx_state_e        state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [CntW-1:0]  nbytes_q, nbytes_d;
  logic [IdxW-1:0]  rd_idx_q, rd_idx_d;
  logic [FillW-1:0] fill_cnt_q, fill_cnt_d;
  logic             done_q, done_d;
  logic [7:0]       buf_q [MAX_PKT];
  logic [15:0]      crc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      pid_q      <= '0;
      nbytes_q   <= '0;
      rd_idx_q   <= '0;
      fill_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      nbytes_q   <= nbytes_d;
      rd_idx_q   <= rd_idx_d;
      fill_cnt_q <= fill_cnt_d;
      done_q     <= done_d;
    end
  end

  // Payload storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (state_q == StFill && i_etWrEn) buf_q[i_etWrIdx] <= i_etWrByte;
  end

  usbfs_crc16 u_crc16 (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .init_i (state_q == StPid),
    .en_i   (state_q == StData && i_txReady),
    .data_i (buf_q[rd_idx_q]),
    .crc_o  (crc)
  );

  // Ready is held low during the done pulse so back-to-back packets get an idle gap.
  assign o_txReqReady = (state_q == StIdle) && !done_q;
  assign o_txDone     = done_q;

  always_comb begin
    state_d        = state_q;
    pid_d          = pid_q;
    nbytes_d       = nbytes_q;
    rd_idx_d       = rd_idx_q;
    fill_cnt_d     = fill_cnt_q;
    o_txValid      = 1'b0;
    o_txLast       = 1'b0;
    o_txData       = 8'h00;
    o_etTxAccepted = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_txReq && o_txReqReady) begin
          pid_d      = i_txPid;
          nbytes_d   = '0;
          fill_cnt_d = '0;
          state_d    = isDataPid(i_txPid) ? StFill : StPid;
        end
      end
      StFill: begin
        o_etTxAccepted = (fill_cnt_q == '0);
        if (i_etWrEn && nbytes_q != CntW'(MAX_PKT)) nbytes_d = nbytes_q + 1'b1;
        if (fill_cnt_q == FillW'(MAX_PKT + 1)) state_d = StPid;
        else                                   fill_cnt_d = fill_cnt_q + 1'b1;
      end
      StPid: begin
        o_txValid = 1'b1;
        o_txData  = {~pid_q, pid_q};
        o_txLast  = !isDataPid(pid_q);
        if (i_txReady) begin
          rd_idx_d = '0;
          if (!isDataPid(pid_q))    state_d = StIdle;
          else if (nbytes_q == '0)  state_d = StCrcLo;
          else                      state_d = StData;
        end
      end
      StData: begin
        o_txValid = 1'b1;
        o_txData  = buf_q[rd_idx_q];
        if (i_txReady) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (CntW'(rd_idx_q) + 1'b1 == nbytes_q) state_d = StCrcLo;
        end
      end
      StCrcLo: begin
        o_txValid = 1'b1;
        o_txData  = ~crc[7:0];
        if (i_txReady) state_d = StCrcHi;
      end
      StCrcHi: begin
        o_txValid = 1'b1;
        o_txData  = ~crc[15:8];
        o_txLast  = 1'b1;
        if (i_txReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    done_d = o_txValid && i_txReady && o_txLast;
  end

endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// Directed bench for usbfs_tx_pkt with MAX_PKT=8 and MAX_PKT=16 instances.
module tb_usbfs_tx_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic       req8, req16;
  logic [3:0] txpid;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [7:0] wr_byte;
  logic       ready;
  logic       sel;

  logic       rr8, done8, acc8, v8, l8;
  logic [7:0] d8;
  logic       rr16, done16, acc16, v16, l16;
  logic [7:0] d16;

  logic       m_reqrdy, m_done, m_acc, m_valid, m_last;
  logic [7:0] m_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];
  logic [3:0] wi_q[$];
  logic [7:0] wb_q[$];
  int         n_done, n_acc, n_hs;

  always #5 clk = ~clk;

  usbfs_tx_pkt #(.MAX_PKT(8)) u_dut8 (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_txReqReady   (rr8),
    .i_txReq        (req8),
    .i_txPid        (txpid),
    .o_txDone       (done8),
    .o_etTxAccepted (acc8),
    .i_etWrEn       (wr_en),
    .i_etWrIdx      (wr_idx[2:0]),
    .i_etWrByte     (wr_byte),
    .o_txValid      (v8),
    .i_txReady      (ready),
    .o_txData       (d8),
    .o_txLast       (l8)
  );

  usbfs_tx_pkt #(.MAX_PKT(16)) u_dut16 (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_txReqReady   (rr16),
    .i_txReq        (req16),
    .i_txPid        (txpid),
    .o_txDone       (done16),
    .o_etTxAccepted (acc16),
    .i_etWrEn       (wr_en),
    .i_etWrIdx      (wr_idx),
    .i_etWrByte     (wr_byte),
    .o_txValid      (v16),
    .i_txReady      (ready),
    .o_txData       (d16),
    .o_txLast       (l16)
  );

  assign m_reqrdy = sel ? rr16   : rr8;
  assign m_done   = sel ? done16 : done8;
  assign m_acc    = sel ? acc16  : acc8;
  assign m_valid  = sel ? v16    : v8;
  assign m_last   = sel ? l16    : l8;
  assign m_data   = sel ? d16    : d8;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: reflected CRC16, returns the complemented value.
  function automatic logic [15:0] ref_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pl_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pl_q[k][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  function automatic void mk_exp(input logic [7:0] pidb);
    logic [15:0] c;
    c = ref_crc();
    exp_q.delete();
    exp_q.push_back(pidb);
    foreach (pl_q[k]) exp_q.push_back(pl_q[k]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endfunction

  // Requests one packet, feeds wi_q/wb_q as writes from cycle wr_start of FILL, stalls ready
  // for stall_len cycles at byte stall_at, optionally pulses reset when byte rst_at is offered.
  task automatic run_pkt(input string tag, input bit s, input logic [3:0] p, input int wr_start,
                         input int stall_at, input int stall_len, input int rst_at);
    int  stall_cnt;
    bit  stalled, fin, aborted;
    sel = s;
    @(posedge clk); #1;
    check({tag, "_reqready"}, 16'(m_reqrdy), 16'd1);
    txpid = p;
    if (s) req16 = 1'b1; else req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0; req16 = 1'b0;
    n_done = 0; n_acc = 0; n_hs = 0;
    stall_cnt = 0; stalled = 0; fin = 0; aborted = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (m_acc) n_acc++;
      wr_en = 1'b0;
      if (cyc >= wr_start && cyc - wr_start < wi_q.size()) begin
        wr_en   = 1'b1;
        wr_idx  = wi_q[cyc - wr_start];
        wr_byte = wb_q[cyc - wr_start];
      end
      ready = 1'b1;
      if (m_done) begin
        n_done++;
        check({tag, "_reqready_in_done"}, 16'(m_reqrdy), 16'd0);
        fin = 1;
      end else if (m_valid && n_hs == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_rst_valid"}, 16'(m_valid), 16'd0);
        check({tag, "_rst_last"}, 16'(m_last), 16'd0);
        check({tag, "_rst_reqready"}, 16'(m_reqrdy), 16'd1);
        check({tag, "_rst_done"}, 16'(m_done), 16'd0);
        aborted = 1; fin = 1;
      end else if (m_valid) begin
        if (!stalled && n_hs == stall_at && stall_len > 0) begin
          stall_cnt = stall_len;
          stalled   = 1;
        end
        if (stall_cnt > 0) begin
          ready = 1'b0;
          stall_cnt--;
        end
        if (n_hs < exp_q.size()) begin
          check($sformatf("%s_byte%0d", tag, n_hs), 16'(m_data), 16'(exp_q[n_hs]));
          check($sformatf("%s_last%0d", tag, n_hs), 16'(m_last),
                16'(n_hs == exp_q.size() - 1));
        end else begin
          check($sformatf("%s_extra_byte%0d", tag, n_hs), 16'(m_valid), 16'd0);
        end
        if (ready) n_hs++;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    wr_en = 1'b0;
    ready = 1'b1;
    if (!aborted) begin
      check({tag, "_finished"}, 16'(fin), 16'd1);
      check({tag, "_nbytes"}, 16'(n_hs), 16'(exp_q.size()));
      check({tag, "_done_pulses"}, 16'(n_done), 16'd1);
      check({tag, "_accepted_pulses"}, 16'(n_acc), 16'(p == 4'b0011 || p == 4'b1011));
    end
  endtask

  initial begin
    rst = 1'b1; req8 = 1'b0; req16 = 1'b0; txpid = 4'h0;
    wr_en = 1'b0; wr_idx = 4'h0; wr_byte = 8'h00; ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_reqready8", 16'(rr8), 16'd1);
    check("rst_valid8", 16'(v8), 16'd0);
    check("rst_last8", 16'(l8), 16'd0);
    check("rst_done8", 16'(done8), 16'd0);
    check("rst_acc8", 16'(acc8), 16'd0);
    check("rst_reqready16", 16'(rr16), 16'd1);
    check("rst_valid16", 16'(v16), 16'd0);

    // DATA0 with empty payload.
    wi_q.delete(); wb_q.delete();
    exp_q = '{8'hC3, 8'h00, 8'h00};
    run_pkt("t1_data0_empty", 1'b0, 4'b0011, 2, -1, 0, -1);

    // Handshake-only packet.
    exp_q = '{8'hD2};
    run_pkt("t2_ack", 1'b0, 4'b0010, 2, -1, 0, -1);

    // DATA1 "123456789" on the 16-byte instance.
    wi_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    wb_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'hC8, 8'hB4};
    run_pkt("t3_crc_check", 1'b1, 4'b1011, 2, -1, 0, -1);

    // Nine writes into the 8-byte buffer: count must saturate at 8.
    wi_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    wb_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
    pl_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    mk_exp(8'hC3);
    run_pkt("t4_full", 1'b0, 4'b0011, 1, -1, 0, -1);

    // Backpressure mid-payload.
    wi_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    wb_q = '{8'hA1, 8'h5B, 8'h3C, 8'hF0, 8'h0E};
    pl_q = '{8'hA1, 8'h5B, 8'h3C, 8'hF0, 8'h0E};
    mk_exp(8'hC3);
    run_pkt("t5_stall", 1'b1, 4'b0011, 2, 3, 5, -1);

    // Reset while payload is streaming, then a clean packet.
    wi_q = '{4'd0, 4'd1, 4'd2};
    wb_q = '{8'h11, 8'h22, 8'h33};
    pl_q = '{8'h11, 8'h22, 8'h33};
    mk_exp(8'h4B);
    run_pkt("t6_abort", 1'b0, 4'b1011, 2, -1, 0, 2);
    wi_q = '{4'd0, 4'd1};
    wb_q = '{8'hAA, 8'h55};
    pl_q = '{8'hAA, 8'h55};
    mk_exp(8'hC3);
    run_pkt("t6_after_rst", 1'b0, 4'b0011, 2, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
